// File: rtl/prod_acc.sv
// Sums N_TERMS unsigned products (e.g. from mul_4) into one result, with
// valid/ready handshakes on both the product input and the result output.
module prod_acc #(
  parameter int PROD_W  = 8,
  parameter int N_TERMS = 4,
  localparam int ACC_W  = PROD_W + $clog2(N_TERMS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [ACC_W-1:0]  sum_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a raised valid_o (with sum_o)
  // holds until it is taken or the block is cleared or reset.

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  typedef enum logic {
    S_ACC  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   sum_q;
  logic [ACC_W-1:0]   term;
  logic [CNT_W-1:0]   cnt_q;
  logic               valid_q;
  logic               accept;
  logic               last;

  assign term    = ACC_W'(prod_i);
  assign ready_o = rst_ni && (state_q == S_ACC);
  assign accept  = valid_i && ready_o;
  assign last    = (cnt_q == CNT_W'(N_TERMS - 1));
  assign sum_o   = sum_q;
  assign valid_o = valid_q;
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (accept && last) state_d = S_DONE;
      S_DONE:  if (ready_i)        state_d = S_ACC;
      default:                     state_d = S_ACC;
    endcase
    if (clear_i) state_d = S_ACC;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clear_i) begin
        // sum_q deliberately survives a clear; only in-flight work is dropped
        acc_q   <= '0;
        cnt_q   <= '0;
        valid_q <= 1'b0;
      end else if (accept) begin
        if (last) begin
          sum_q   <= acc_q + term;
          valid_q <= 1'b1;
          acc_q   <= '0;
          cnt_q   <= '0;
        end else begin
          acc_q <= acc_q + term;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prod_acc.sv
// Bench for prod_acc: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a batch-level model.
module tb_prod_acc;

  localparam int PROD_W  = 8;
  localparam int N_TERMS = 4;
  localparam int ACC_W   = 10;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clear_i;
  logic [PROD_W-1:0] prod_i;
  logic              valid_i;
  logic              ready_o;
  logic [ACC_W-1:0]  sum_o;
  logic              valid_o;
  logic              ready_i;
  logic              state_o;

  int n_checks = 0;
  int n_errors = 0;

  prod_acc #(.PROD_W(PROD_W), .N_TERMS(N_TERMS)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .prod_i  (prod_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sum_o   (sum_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .state_o (state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: list of accepted terms in the current batch, a pending
  // result flag and the last produced sum
  int               m_terms[$];
  bit               m_pending = 1'b0;
  int               m_sum     = 0;
  bit               armed     = 1'b0;
  logic [ACC_W-1:0] exp_q[$];

  always @(posedge clk_i) begin
    int s;
    armed = 1'b1;
    if (!rst_ni) begin
      m_terms.delete();
      m_pending = 1'b0;
      m_sum     = 0;
      exp_q.delete();
    end else if (clear_i) begin
      m_terms.delete();
      m_pending = 1'b0;
      exp_q.delete();
    end else if (m_pending) begin
      if (ready_i) begin
        m_pending = 1'b0;
        void'(exp_q.pop_front());
      end
    end else if (valid_i) begin
      m_terms.push_back(int'(prod_i));
      if (m_terms.size() == N_TERMS) begin
        s = 0;
        foreach (m_terms[i]) s += m_terms[i];
        m_sum     = s;
        m_pending = 1'b1;
        exp_q.push_back(ACC_W'(s));
        m_terms.delete();
      end
    end
  end

  // scoreboard / compare process, sampled on the falling edge
  always @(negedge clk_i) begin
    if (armed) begin
      check("ready_o", int'(ready_o), int'(rst_ni && !m_pending));
      check("valid_o", int'(valid_o), int'(m_pending));
      check("sum_o",   int'(sum_o),   m_sum);
      if (valid_o && ready_i && rst_ni && !clear_i) begin
        if (exp_q.size() == 0) check("handshake_with_empty_exp_q", 1, 0);
        else                   check("handshake_sum", int'(sum_o), int'(exp_q[0]));
      end
    end
  end

  // driver tasks: set inputs, then advance to just after the next rising edge
  task automatic step(input logic v, input int p, input logic r, input logic clr);
    valid_i = v;
    prod_i  = PROD_W'(p);
    ready_i = r;
    clear_i = clr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_batch(input int a, input int b, input int c, input int d);
    step(1'b1, a, 1'b1, 1'b0);
    step(1'b1, b, 1'b1, 1'b0);
    step(1'b1, c, 1'b1, 1'b0);
    step(1'b1, d, 1'b1, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; valid_i = 1'b0; prod_i = '0; ready_i = 1'b0;

    // reset with a term presented
    for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 1'b1, 1'b0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_sum",   int'(sum_o),   0);
    check("rst_ready", int'(ready_o), 0);
    rst_ni = 1'b1;
    #1;
    check("post_rst_ready", int'(ready_o), 1);

    // max values: 4 * 225 = 900
    send_batch(225, 225, 225, 225);
    check("max_valid_latency", int'(valid_o), 1);
    check("max_sum", int'(sum_o), 900);
    step(1'b1, 225, 1'b1, 1'b0);
    check("max_handshake_drop", int'(valid_o), 0);
    check("max_sum_kept", int'(sum_o), 900);

    // backpressure in DONE
    send_batch(1, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 7, 1'b0, 1'b0);
      check("bp_valid", int'(valid_o), 1);
      check("bp_sum",   int'(sum_o),   4);
      check("bp_ready", int'(ready_o), 0);
    end
    step(1'b1, 7, 1'b1, 1'b0);
    check("bp_release", int'(valid_o), 0);
    send_batch(7, 7, 7, 7);
    check("bp_next_clean", int'(sum_o), 28);
    step(1'b0, 0, 1'b1, 1'b0);

    // bubbles with a zero-valued term
    step(1'b1, 1, 1'b1, 1'b0); step(1'b0, 9, 1'b1, 1'b0);
    step(1'b1, 0, 1'b1, 1'b0); step(1'b0, 9, 1'b1, 1'b0); step(1'b0, 9, 1'b1, 1'b0);
    step(1'b1, 2, 1'b1, 1'b0); step(1'b0, 9, 1'b1, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0);
    check("bubble_valid", int'(valid_o), 1);
    check("bubble_sum", int'(sum_o), 6);
    step(1'b0, 0, 1'b1, 1'b0);

    // clear mid-batch, then clear while a result is pending
    step(1'b1, 10, 1'b1, 1'b0);
    step(1'b1, 20, 1'b1, 1'b0);
    step(1'b1, 50, 1'b1, 1'b1);
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 4, 1'b0, 1'b0);
    check("clear_sum", int'(sum_o), 10);
    step(1'b0, 0, 1'b0, 1'b1);
    check("clear_done_valid", int'(valid_o), 0);
    check("clear_done_sum", int'(sum_o), 10);
    check("clear_done_ready", int'(ready_o), 1);

    // reset mid-batch
    step(1'b1, 9, 1'b1, 1'b0);
    step(1'b1, 9, 1'b1, 1'b0);
    step(1'b1, 9, 1'b1, 1'b0);
    rst_ni = 1'b0;
    step(1'b0, 0, 1'b1, 1'b0);
    rst_ni = 1'b1;
    send_batch(2, 2, 2, 2);
    check("rst_mid_sum", int'(sum_o), 8);
    step(1'b0, 0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_ni = ($urandom_range(0, 299) != 0);
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
    end
    rst_ni = 1'b1;
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
